// File: rtl/mpss_uart_arb_pkg.sv
// rtl/mpss_uart_arb_pkg.sv - shared types, constants and helpers for the mpss UART arbiter
package mpss_uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [7:0] DEF_TAG_BASE = 8'h30;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mpss_rr_pick.sv
// rtl/mpss_rr_pick.sv - combinational round-robin picker, search starts just after the last grant
module mpss_rr_pick
    import mpss_uart_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          hit
);

    int unsigned   jw;
    logic [IW-1:0] j;

    // Walk from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        winner = last;
        hit    = 1'b0;
        jw     = 0;
        j      = '0;
        for (int unsigned i = N; i >= 1; i--) begin
            jw = (32'(last) + i) % N;
            j  = jw[IW-1:0];
            if (req[j]) begin
                winner = j;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpss_uart_arb.sv
// rtl/mpss_uart_arb.sv - round-robin packet-locked arbiter sharing one UART TX among requesters
module mpss_uart_arb
    import mpss_uart_arb_pkg::*;
#(
    parameter int unsigned        NUM_REQ   = 4,
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        MAX_BURST = 16,
    parameter int unsigned        TAG_EN    = 1,
    parameter logic [DATA_W-1:0]  TAG_BASE  = DATA_W'(DEF_TAG_BASE),
    localparam int unsigned       IW        = idx_w(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        tx_valid_o,
    output logic [DATA_W-1:0]           tx_data_o,
    input  logic                        tx_ready_i,
    output logic [IW-1:0]               owner_o,
    output logic                        busy_o
);

    localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic              load_ok;
    logic              acc;
    logic              own_valid;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic [IW-1:0]     winner;
    logic              win_hit;

    assign load_ok = !tx_valid_q || tx_ready_i;
    assign acc     = (state_q == DATA) && load_ok && own_valid;

    mpss_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req    (req_valid_i),
        .last   (owner_q),
        .winner (winner),
        .hit    (win_hit)
    );

    // Owner-side mux; req_ready_o can only ever be set on the owner's bit.
    always_comb begin
        own_valid   = 1'b0;
        own_last    = 1'b0;
        own_data    = '0;
        req_ready_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IW'(k)) begin
                own_valid      = req_valid_i[k];
                own_last       = req_last_i[k];
                own_data       = req_data_i[k*DATA_W +: DATA_W];
                req_ready_o[k] = (state_q == DATA) && load_ok;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (load_ok) begin
            tx_valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (win_hit) begin
                    owner_d = winner;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (TAG_EN != 0) ? TAG : DATA;
                end
            end
            TAG: begin
                if (load_ok) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = TAG_BASE + DATA_W'(owner_q);
                    state_d    = DATA;
                end
            end
            DATA: begin
                // A stalled owner keeps the grant so packets never interleave.
                if (acc) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = own_data;
                    cnt_d      = cnt_q + 8'd1;
                    if (own_last || cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            owner_q    <= IW'(NUM_REQ - 1);
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign owner_o    = owner_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_mpss_uart_arb.sv
// tb/tb_mpss_uart_arb.sv - scoreboard bench for mpss_uart_arb with directed packet stimulus
module tb_mpss_uart_arb;

    localparam int NREQ = 4;

    logic              clk_i = 1'b0;
    logic              arst_ni;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ*8-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_ready_i;
    logic [1:0]        owner_o;
    logic              busy_o;

    typedef logic [8:0] ent_q_t [$];
    ent_q_t     rq [NREQ];
    logic [7:0] exp_q [$];
    logic [NREQ-1:0] en;
    logic       tx_rdy;
    int         passed = 0;
    int         total  = 0;
    int         cyc    = 0;
    int         tx_cnt = 0;
    bit         lat_arm = 1'b0;
    int         t_req = -1, t_tag = -1, t_d0 = -1, t_d1 = -1, lat_n = 0;

    mpss_uart_arb #(
        .NUM_REQ   (NREQ),
        .DATA_W    (8),
        .MAX_BURST (16),
        .TAG_EN    (1),
        .TAG_BASE  (8'h30)
    ) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .owner_o     (owner_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push_req(input int k, input logic [7:0] d, input logic last);
        rq[k].push_back({last, d});
    endtask

    task automatic expect_b(input logic [7:0] d);
        exp_q.push_back(d);
    endtask

    function automatic bit rq_pending();
        for (int k = 0; k < NREQ; k++) if (rq[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rq_pending()) && n < 400) begin
            @(posedge clk_i); #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_tx(input string name, input int target);
        int n = 0;
        while (tx_cnt < target && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check(name, 32'(tx_cnt >= target), 1);
    endtask

    // Requester driver: present queue heads on the falling edge, retire accepted bytes just before the rising edge.
    initial begin
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_ready_i  = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            for (int k = 0; k < NREQ; k++) begin
                if (rq[k].size() > 0 && en[k]) begin
                    req_valid_i[k]       = 1'b1;
                    req_data_i[k*8 +: 8] = rq[k][0][7:0];
                    req_last_i[k]        = rq[k][0][8];
                end else begin
                    req_valid_i[k]       = 1'b0;
                    req_data_i[k*8 +: 8] = 8'h00;
                    req_last_i[k]        = 1'b0;
                end
            end
            tx_ready_i = tx_rdy;
            if (lat_arm && req_valid_i != '0 && t_req < 0) t_req = cyc;
            #4;
            for (int k = 0; k < NREQ; k++)
                if (req_valid_i[k] && req_ready_o[k]) void'(rq[k].pop_front());
        end
    end

    // UART-side monitor: every byte handed to the UART is popped from the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            #4;
            if (tx_valid_o && tx_ready_i) begin
                tx_cnt++;
                if (lat_arm) begin
                    if (lat_n == 0) t_tag = cyc;
                    else if (lat_n == 1) t_d0 = cyc;
                    else if (lat_n == 2) t_d1 = cyc;
                    lat_n++;
                end
                if (exp_q.size() == 0) check("tx_extra", 32'(exp_q.size()), 1);
                else check("tx_byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        logic [7:0] held;
        arst_ni = 1'b0;
        en      = '1;
        tx_rdy  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_tx_valid", 32'(tx_valid_o), 0);
        check("rst_tx_data", 32'(tx_data_o), 0);
        check("rst_req_ready", 32'(req_ready_o), 0);
        check("rst_owner", 32'(owner_o), 3);
        check("rst_busy", 32'(busy_o), 0);
        arst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Lone requester 2, two-byte packet, with latency measurement
        lat_arm = 1'b1;
        n = tx_cnt;
        push_req(2, 8'h41, 1'b0);
        push_req(2, 8'h42, 1'b1);
        expect_b(8'h32); expect_b(8'h41); expect_b(8'h42);
        wait_tx("t1_wait", n + 2);
        check("t1_busy_fall", 32'(busy_o), 0);
        check("t1_last_loaded", 32'(tx_data_o), 32'h42);
        wait_drain("t1_drain");
        lat_arm = 1'b0;
        check("t1_owner", 32'(owner_o), 2);
        check("t1_lat_tag", 32'(t_tag - t_req), 2);
        check("t1_lat_data", 32'(t_d0 - t_req), 3);
        check("t1_b2b", 32'(t_d1 - t_d0), 1);

        // All four requesters, two 1-byte packets each; search resumes after owner 2
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < NREQ; j++)
                push_req(j, (r == 0 ? 8'h50 : 8'h60) | 8'(j), 1'b1);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) begin
                k = (3 + i) % NREQ;
                expect_b(8'h30 + 8'(k));
                expect_b((r == 0 ? 8'h50 : 8'h60) | 8'(k));
            end
        wait_drain("t2_drain");
        check("t2_owner", 32'(owner_o), 2);

        // Burst cap: 20-byte packet from requester 0 alone splits 16 + 4 with a fresh tag
        for (int i = 0; i < 20; i++) push_req(0, 8'(i), i == 19);
        expect_b(8'h30);
        for (int i = 0; i < 16; i++) expect_b(8'(i));
        expect_b(8'h30);
        for (int i = 16; i < 20; i++) expect_b(8'(i));
        wait_drain("t3a_drain");

        // Burst cap with requester 1 arriving mid-burst: it takes the slot after byte 16
        for (int i = 0; i < 20; i++) push_req(0, 8'h20 + 8'(i), i == 19);
        n = 0;
        while (!(busy_o && owner_o == 2'd0) && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("t3b_grant0", 32'(busy_o && owner_o == 2'd0), 1);
        push_req(1, 8'h77, 1'b1);
        expect_b(8'h30);
        for (int i = 0; i < 16; i++) expect_b(8'h20 + 8'(i));
        expect_b(8'h31); expect_b(8'h77);
        expect_b(8'h30);
        for (int i = 16; i < 20; i++) expect_b(8'h20 + 8'(i));
        wait_drain("t3b_drain");

        // Backpressure: UART stalls five cycles mid-packet
        for (int i = 0; i < 6; i++) push_req(1, 8'h80 + 8'(i), i == 5);
        expect_b(8'h31);
        for (int i = 0; i < 6; i++) expect_b(8'h80 + 8'(i));
        n = tx_cnt;
        wait_tx("t4_wait", n + 3);
        tx_rdy = 1'b0;
        held = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i); #3;
            check("t4_valid_held", 32'(tx_valid_o), 1);
            check("t4_ready_low", 32'(req_ready_o), 0);
            if (i == 0) held = tx_data_o;
            else check("t4_data_stable", 32'(tx_data_o), 32'(held));
        end
        @(posedge clk_i); #1;
        tx_rdy = 1'b1;
        wait_drain("t4_drain");

        // Owner stall: requester 2 pauses mid-packet while requester 3 waits
        push_req(2, 8'h90, 1'b0); push_req(2, 8'h91, 1'b0); push_req(2, 8'h92, 1'b1);
        push_req(3, 8'hA0, 1'b1);
        expect_b(8'h32); expect_b(8'h90); expect_b(8'h91); expect_b(8'h92);
        expect_b(8'h33); expect_b(8'hA0);
        n = tx_cnt;
        wait_tx("t5_wait", n + 2);
        en[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i); #3;
            check("t5_other_ready", 32'(req_ready_o[3]), 0);
            check("t5_owner_held", 32'(owner_o), 2);
            check("t5_busy_held", 32'(busy_o), 1);
        end
        @(posedge clk_i); #1;
        en[2] = 1'b1;
        wait_drain("t5_drain");

        // Asynchronous reset mid-packet, then restart from index 0
        for (int i = 0; i < 6; i++) push_req(0, 8'hB0 + 8'(i), i == 5);
        expect_b(8'h30);
        for (int i = 0; i < 6; i++) expect_b(8'hB0 + 8'(i));
        n = tx_cnt;
        wait_tx("t6_wait", n + 3);
        #1;
        arst_ni = 1'b0;
        #1;
        check("t6_rst_valid", 32'(tx_valid_o), 0);
        check("t6_rst_busy", 32'(busy_o), 0);
        check("t6_rst_owner", 32'(owner_o), 3);
        check("t6_rst_ready", 32'(req_ready_o), 0);
        exp_q.delete();
        for (int j = 0; j < NREQ; j++) rq[j].delete();
        @(posedge clk_i); #1;
        push_req(2, 8'hC0, 1'b1);
        push_req(1, 8'hD0, 1'b1);
        expect_b(8'h31); expect_b(8'hD0); expect_b(8'h32); expect_b(8'hC0);
        arst_ni = 1'b1;
        wait_drain("t6_drain");
        check("t6_owner", 32'(owner_o), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
